// File: rtl/sfq_rx_pkg.sv
// Shared types and helpers for the SFQ lane deserialiser.
// SFQ_DESER_PARITY_EN adds an even-parity bit above the data bits of each word.
package sfq_rx_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;

  localparam int unsigned FIFO_DEPTH = 2;

`ifdef SFQ_DESER_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif

  // Increment that sticks at all-ones for a counter of width w (w <= 32)
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
    logic [32:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    return (val == max_v[31:0]) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sfq_word_fifo.sv
// Two-entry shift FIFO; slot0 is always the head so dout comes straight from a flop.
module sfq_word_fifo
  import sfq_rx_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] slot [FIFO_DEPTH];
  logic [DW-1:0] slot_n [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld, vld_n;
  logic pop_ok, push_ok;

  // Pop frees the head before the push is placed, so full+pop+push never drops
  always_comb begin
    pop_ok  = pop & vld[0];
    push_ok = push & (~vld[1] | pop_ok);
    slot_n  = slot;
    vld_n   = vld;
    if (pop_ok) begin
      if (vld[1]) begin
        slot_n[0] = slot[1];
        if (push_ok) slot_n[1] = din;
        else         vld_n[1]  = 1'b0;
      end else if (push_ok) begin
        slot_n[0] = din;
      end else begin
        vld_n[0] = 1'b0;
      end
    end else if (push_ok) begin
      if (vld[0]) begin
        slot_n[1] = din;
        vld_n[1]  = 1'b1;
      end else begin
        slot_n[0] = din;
        vld_n[0]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      vld     <= '0;
    end else begin
      slot[0] <= slot_n[0];
      slot[1] <= slot_n[1];
      vld     <= vld_n;
    end
  end

  assign dout  = slot[0];
  assign full  = vld[1];
  assign empty = ~vld[0];

endmodule

// File: rtl/sfq_deser_rx.sv
// Samples one DRO SFQ lane per clk, packs WIDTH bits LSB-first and queues words for the binary side.
// SFQ_DESER_PARITY_EN widens word by one even-parity MSB.
module sfq_deser_rx
  import sfq_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OVF_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sfq_data,
  output logic                   sfq_clr,
  input  logic                   en,
  output logic [WIDTH+PAR_W-1:0] word,
  output logic                   word_vld,
  input  logic                   word_rdy,
  output logic [OVF_W-1:0]       ovf_cnt,
  output logic                   busy
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW    = WIDTH + PAR_W;

  rx_state_e        state, state_n;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic [WIDTH-2:0] shreg, shreg_n;
  logic [WIDTH-1:0] data_word;
  logic [DW-1:0]    push_word;
  logic             clr_n, push, full, empty, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state plus sampling; the last bit goes straight into the pushed word
  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    clr_n     = 1'b0;
    push      = 1'b0;
    data_word = {sfq_data, shreg};
    case (state)
      IDLE: begin
        bit_idx_n = '0;
        shreg_n   = '0;
        if (en) state_n = COLLECT;
      end
      COLLECT: begin
        if (!en) begin
          state_n   = IDLE;
          bit_idx_n = '0;
          shreg_n   = '0;
        end else begin
          clr_n = 1'b1;
          if (bit_idx == IDX_W'(WIDTH - 1)) begin
            push      = 1'b1;
            bit_idx_n = '0;
            shreg_n   = '0;
          end else begin
            for (int i = 0; i < int'(WIDTH) - 1; i++) begin
              if (bit_idx == IDX_W'(i)) shreg_n[i] = sfq_data;
            end
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SFQ_DESER_PARITY_EN
  assign push_word = {^data_word, data_word};
`else
  assign push_word = data_word;
`endif

  // A full FIFO only takes the word if the consumer pops on the same edge
  assign drop = push & full & ~word_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
      sfq_clr <= 1'b0;
      busy    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      sfq_clr <= clr_n;
      busy    <= (state_n != IDLE);
      if (drop) ovf_cnt <= OVF_W'(sat_inc(32'(ovf_cnt), OVF_W));
    end
  end

  sfq_word_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_word),
    .pop   (word_rdy),
    .dout  (word),
    .full  (full),
    .empty (empty)
  );

  assign word_vld = ~empty;

endmodule

// File: tb/tb_sfq_deser_rx.sv
// Scoreboard bench for sfq_deser_rx: a negedge model predicts each edge and queues expected words.
module tb_sfq_deser_rx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OVF_W = 2;
`ifdef SFQ_DESER_PARITY_EN
  localparam int unsigned WW = WIDTH + 1;
`else
  localparam int unsigned WW = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sfq_data = 1'b0;
  logic             en = 1'b0;
  logic             word_rdy = 1'b1;
  logic             sfq_clr, word_vld, busy;
  logic [WW-1:0]    word;
  logic [OVF_W-1:0] ovf_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [WW-1:0]    exp_q[$];
  logic             m_coll = 1'b0;
  int               m_idx = 0;
  logic [WIDTH-1:0] m_bits = '0;
  logic             exp_clr = 1'b0;
  logic [OVF_W-1:0] exp_ovf = '0;

  always #5 clk = ~clk;

  sfq_deser_rx #(
    .WIDTH (WIDTH),
    .OVF_W (OVF_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sfq_data (sfq_data),
    .sfq_clr  (sfq_clr),
    .en       (en),
    .word     (word),
    .word_vld (word_vld),
    .word_rdy (word_rdy),
    .ovf_cnt  (ovf_cnt),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic [WIDTH-1:0] d);
`ifdef SFQ_DESER_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Check current outputs, then predict what the coming posedge does
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_coll  = 1'b0;
      m_idx   = 0;
      m_bits  = '0;
      exp_clr = 1'b0;
      exp_ovf = '0;
    end else begin
      check("word_vld", 32'(word_vld), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("word", 32'(word), 32'(exp_q[0]));
      check("sfq_clr", 32'(sfq_clr), 32'(exp_clr));
      check("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
      check("busy", 32'(busy), 32'(m_coll));
      if (word_rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      exp_clr = 1'b0;
      if (!m_coll) begin
        if (en) m_coll = 1'b1;
      end else if (!en) begin
        m_coll = 1'b0;
        m_idx  = 0;
        m_bits = '0;
      end else begin
        m_bits[m_idx] = sfq_data;
        exp_clr = 1'b1;
        if (m_idx == int'(WIDTH) - 1) begin
          if (exp_q.size() < 2) exp_q.push_back(mk(m_bits));
          else if (exp_ovf != '1) exp_ovf = exp_ovf + 1'b1;
          m_idx  = 0;
          m_bits = '0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic cyc(input logic d);
    sfq_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < int'(WIDTH); i++) cyc(w[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"}, 32'(word_vld), 32'd0);
    check({tag, "_word"}, 32'(word), 32'd0);
    check({tag, "_clr"}, 32'(sfq_clr), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_cnt), 32'd0);
  endtask

  logic [WIDTH-1:0] w85, w3;

  initial begin
    w85 = 8'h85;
    w3  = 8'hC4;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single word, pulses on samples 0,2,7, latency check
    en = 1'b1;
    word_rdy = 1'b1;
    cyc(1'b0);
    for (int i = 0; i < int'(WIDTH); i++) begin
      cyc(w85[i]);
      if (i == int'(WIDTH) - 2) check("t1_early_vld", 32'(word_vld), 32'd0);
    end
    check("t1_vld", 32'(word_vld), 32'd1);
    check("t1_word", 32'(word), 32'(mk(8'h85)));
    en = 1'b0;
    cyc(1'b0);
    check("t1_vld_gone", 32'(word_vld), 32'd0);

    // Three words, no ready: third dropped
    word_rdy = 1'b0;
    en = 1'b1;
    cyc(1'b0);
    send_word(8'hA7);
    send_word(8'h1E);
    send_word(8'h6B);
    en = 1'b0;
    cyc(1'b0);
    check("t2_ovf", 32'(ovf_cnt), 32'd1);
    check("t2_head", 32'(word), 32'(mk(8'hA7)));

    // Full FIFO, push and pop on the same edge
    en = 1'b1;
    cyc(1'b0);
    for (int i = 0; i < int'(WIDTH); i++) begin
      word_rdy = (i == int'(WIDTH) - 1);
      cyc(w3[i]);
    end
    word_rdy = 1'b0;
    en = 1'b0;
    cyc(1'b0);
    check("t3_ovf", 32'(ovf_cnt), 32'd1);
    check("t3_head", 32'(word), 32'(mk(8'h1E)));
    word_rdy = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    check("t3_drained", 32'(word_vld), 32'd0);

    // Abort a partial word, then restart from bit 0
    en = 1'b1;
    cyc(1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1);
    en = 1'b0;
    cyc(1'b0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_clr", 32'(sfq_clr), 32'd0);
    cyc(1'b1);
    check("t5_clr_idle", 32'(sfq_clr), 32'd0);
    check("t5_no_word", 32'(word_vld), 32'd0);
    en = 1'b1;
    cyc(1'b0);
    send_word(8'h3C);
    check("t5_word", 32'(word), 32'(mk(8'h3C)));
    en = 1'b0;
    cyc(1'b0);

    // Reset mid-word with one word held
    word_rdy = 1'b0;
    en = 1'b1;
    cyc(1'b0);
    send_word(8'h91);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b1);
    check("t6_held", 32'(word_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    word_rdy = 1'b1;
    cyc(1'b0);
    send_word(8'h5A);
    check("t6_word", 32'(word), 32'(mk(8'h5A)));
    en = 1'b0;
    cyc(1'b0);

    // Saturating drop counter: two stored, five dropped
    word_rdy = 1'b0;
    en = 1'b1;
    cyc(1'b0);
    for (int k = 0; k < 7; k++) send_word(WIDTH'($urandom));
    en = 1'b0;
    cyc(1'b0);
    check("t4_ovf_sat", 32'(ovf_cnt), 32'd3);
    word_rdy = 1'b1;
    repeat (3) cyc(1'b0);
    check("t4_drained", 32'(word_vld), 32'd0);

    repeat (2) cyc(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
